// File: rtl/fault_confinement_pkg.sv
// CAN fault-confinement shared types and limits.
// Package can_fce_pkg: fce_state_t, limit constants, TEC_W/REC_W.
package can_fce_pkg;

  typedef enum logic [1:0] {
    ERROR_ACTIVE  = 2'd0,
    ERROR_PASSIVE = 2'd1,
    BUS_OFF       = 2'd2
  } fce_state_t;

  localparam int TEC_W = 9;
  localparam int REC_W = 8;

  localparam int PASSIVE_LIMIT = 128;
  localparam int BUSOFF_LIMIT  = 256;
  localparam int RECOVERY_CNT  = 128;
  localparam int REC_RELOAD    = 120;
  localparam int WARN_LIMIT    = 96;

  localparam int RCV_W = $clog2(RECOVERY_CNT);

  localparam logic [TEC_W-1:0] TEC_PASSIVE = TEC_W'(PASSIVE_LIMIT);
  localparam logic [TEC_W-1:0] TEC_BUSOFF  = TEC_W'(BUSOFF_LIMIT);
  localparam logic [TEC_W-1:0] TEC_WARN    = TEC_W'(WARN_LIMIT);

  localparam logic [REC_W-1:0] REC_PASSIVE = REC_W'(PASSIVE_LIMIT);
  localparam logic [REC_W-1:0] REC_RELOAD_V = REC_W'(REC_RELOAD);
  localparam logic [REC_W-1:0] REC_WARN    = REC_W'(WARN_LIMIT);
  localparam logic [REC_W-1:0] REC_MAX     = '1;

endpackage

// File: rtl/fault_confinement_if.sv
// Strobe/status bundle between MAC error handling and fault confinement.
// master: drives error strobes, reads counters/flags. slave: the reverse.
interface fault_confinement_if;
  import can_fce_pkg::*;

  logic             rec_inc1;
  logic             rec_inc8;
  logic             rec_dec1;
  logic             tec_inc8;
  logic             tec_dec1;
  logic             seq11r;
  logic [TEC_W-1:0] tec;
  logic [REC_W-1:0] rec;
  logic             erroractive;
  logic             errorpassive;
  logic             busoff;
  logic             warning;

  modport master (
    output rec_inc1, rec_inc8, rec_dec1,
    output tec_inc8, tec_dec1, seq11r,
    input  tec, rec,
    input  erroractive, errorpassive,
    input  busoff, warning
  );

  modport slave (
    input  rec_inc1, rec_inc8, rec_dec1,
    input  tec_inc8, tec_dec1, seq11r,
    output tec, rec,
    output erroractive, errorpassive,
    output busoff, warning
  );

endinterface

// File: rtl/fault_confinement_busoff_recovery_cnt.sv
// Bus-off recovery: counts seq11r pulses while enabled (node in BUS_OFF).
// Ports: clock, reset (sync, low), i_en, i_seq11r, o_done (128th pulse).
module busoff_recovery_cnt
  import can_fce_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  input  logic i_seq11r,
  output logic o_done
);

  logic [RCV_W-1:0] r_cnt;

  // Counter wraps to 0 on the done edge, so no explicit clear is needed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (i_seq11r) begin
      r_cnt <= r_cnt + RCV_W'(1);
    end
  end

  assign o_done = i_en & i_seq11r & (&r_cnt);

endmodule

// File: rtl/fault_confinement.sv
// CAN fault confinement: TEC/REC counters and node error state.
// Ports: clock, reset (sync, low), bus (slave). Option: FCE_WARNING_EN.
module fault_confinement
  import can_fce_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  fault_confinement_if.slave  bus
);

  logic [TEC_W-1:0] r_tec;
  logic [REC_W-1:0] r_rec;
  fce_state_t       r_state;
  logic             r_active;
  logic             r_passive;
  logic             r_busoff;

  logic [TEC_W-1:0] w_tec_nxt;
  logic [REC_W-1:0] w_rec_nxt;
  fce_state_t       w_state_nxt;
  logic [TEC_W:0]   w_tec_sum;
  logic [REC_W:0]   w_rec_sum;
  logic             w_bo;
  logic             w_done;

  assign w_bo = (r_state == BUS_OFF);

  busoff_recovery_cnt u_rcv (
    .clock    (clock),
    .reset    (reset),
    .i_en     (w_bo),
    .i_seq11r (bus.seq11r),
    .o_done   (w_done)
  );

  always_comb begin
    w_tec_sum = {1'b0, r_tec} + (TEC_W+1)'(8);
    w_rec_sum = {1'b0, r_rec}
              + (bus.rec_inc8 ? (REC_W+1)'(8)
                              : (REC_W+1)'(1));
    w_tec_nxt = r_tec;
    w_rec_nxt = r_rec;
    if (w_bo) begin
      // tec already sits at 256; only recovery moves it.
      if (w_done) begin
        w_tec_nxt = '0;
        w_rec_nxt = '0;
      end
    end else begin
      if (bus.tec_inc8) begin
        if (w_tec_sum >= {1'b0, TEC_BUSOFF})
          w_tec_nxt = TEC_BUSOFF;
        else
          w_tec_nxt = w_tec_sum[TEC_W-1:0];
      end else if (bus.tec_dec1 && r_tec != '0) begin
        w_tec_nxt = r_tec - TEC_W'(1);
      end
      // +8 beats +1 (handled in w_rec_sum); any inc beats dec.
      if (bus.rec_inc8 || bus.rec_inc1) begin
        if (w_rec_sum[REC_W])
          w_rec_nxt = REC_MAX;
        else
          w_rec_nxt = w_rec_sum[REC_W-1:0];
      end else if (bus.rec_dec1) begin
        if (r_rec >= REC_PASSIVE)
          w_rec_nxt = REC_RELOAD_V;
        else if (r_rec != '0)
          w_rec_nxt = r_rec - REC_W'(1);
      end
    end
  end

  always_comb begin
    if (w_tec_nxt >= TEC_BUSOFF)
      w_state_nxt = BUS_OFF;
    else if (w_tec_nxt >= TEC_PASSIVE ||
             w_rec_nxt >= REC_PASSIVE)
      w_state_nxt = ERROR_PASSIVE;
    else
      w_state_nxt = ERROR_ACTIVE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tec     <= '0;
      r_rec     <= '0;
      r_state   <= ERROR_ACTIVE;
      r_active  <= 1'b1;
      r_passive <= 1'b0;
      r_busoff  <= 1'b0;
    end else begin
      r_tec     <= w_tec_nxt;
      r_rec     <= w_rec_nxt;
      r_state   <= w_state_nxt;
      r_active  <= (w_state_nxt == ERROR_ACTIVE);
      r_passive <= (w_state_nxt == ERROR_PASSIVE);
      r_busoff  <= (w_state_nxt == BUS_OFF);
    end
  end

`ifdef FCE_WARNING_EN
  logic r_warning;
  logic w_warn_nxt;

  assign w_warn_nxt = (w_state_nxt != BUS_OFF) &&
                      (w_tec_nxt >= TEC_WARN ||
                       w_rec_nxt >= REC_WARN);

  always_ff @(posedge clock) begin
    if (!reset)
      r_warning <= 1'b0;
    else
      r_warning <= w_warn_nxt;
  end

  assign bus.warning = r_warning;
`else
  assign bus.warning = 1'b0;
`endif

  assign bus.tec          = r_tec;
  assign bus.rec          = r_rec;
  assign bus.erroractive  = r_active;
  assign bus.errorpassive = r_passive;
  assign bus.busoff       = r_busoff;

endmodule

// File: tb/tb_fault_confinement.sv
// Randomized + directed bench for fault_confinement.
// Reference model kept as plain integers following the counting rules.
module tb_fault_confinement;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fault_confinement_if bus ();

  fault_confinement dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  int m_tec = 0;
  int m_rec = 0;
  int m_st  = 0;
  int m_rc  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic model(input bit rst, input bit ri1, input bit ri8,
                       input bit rd1, input bit ti8, input bit td1,
                       input bit sq);
    if (!rst) begin
      m_tec = 0; m_rec = 0; m_rc = 0;
    end else if (m_st == 2) begin
      if (sq) begin
        m_rc++;
        if (m_rc == 128) begin
          m_tec = 0; m_rec = 0; m_rc = 0;
        end
      end
    end else begin
      m_rc = 0;
      if (ri8)      m_rec = sat(m_rec + 8, 255);
      else if (ri1) m_rec = sat(m_rec + 1, 255);
      else if (rd1) m_rec = (m_rec > 127) ? 120
                          : (m_rec > 0) ? m_rec - 1 : 0;
      if (ti8)                   m_tec = sat(m_tec + 8, 256);
      else if (td1 && m_tec > 0) m_tec = m_tec - 1;
    end
    if (m_tec >= 256)                     m_st = 2;
    else if (m_tec >= 128 || m_rec >= 128) m_st = 1;
    else                                  m_st = 0;
  endtask

  function automatic logic [3:0] exp_flags();
    logic w;
`ifdef FCE_WARNING_EN
    w = (m_st != 2) && (m_tec >= 96 || m_rec >= 96);
`else
    w = 1'b0;
`endif
    return {w, m_st == 2, m_st == 1, m_st == 0};
  endfunction

  task automatic step(input bit rst, input bit ri1, input bit ri8,
                      input bit rd1, input bit ti8, input bit td1,
                      input bit sq);
    reset        = rst;
    bus.rec_inc1 = ri1;
    bus.rec_inc8 = ri8;
    bus.rec_dec1 = rd1;
    bus.tec_inc8 = ti8;
    bus.tec_dec1 = td1;
    bus.seq11r   = sq;
    @(posedge clock);
    model(rst, ri1, ri8, rd1, ti8, td1, sq);
    #1;
    chk("tec", 32'(bus.tec), 32'(m_tec));
    chk("rec", 32'(bus.rec), 32'(m_rec));
    chk("flags", 32'({bus.warning, bus.busoff,
                      bus.errorpassive, bus.erroractive}),
         32'(exp_flags()));
  endtask

  task automatic rst1();      step(0,0,0,0,0,0,0); endtask
  task automatic ti8(int n);  repeat (n) step(1,0,0,0,1,0,0); endtask
  task automatic ri8(int n);  repeat (n) step(1,0,1,0,0,0,0); endtask
  task automatic ri1(int n);  repeat (n) step(1,1,0,0,0,0,0); endtask
  task automatic sq(int n);   repeat (n) step(1,0,0,0,0,0,1); endtask

  initial begin
    bus.rec_inc1 = 0; bus.rec_inc8 = 0; bus.rec_dec1 = 0;
    bus.tec_inc8 = 0; bus.tec_dec1 = 0; bus.seq11r = 0;
    rst1(); rst1();
    chk("rst_tec", 32'(bus.tec), 0);
    chk("rst_act", 32'(bus.erroractive), 1);

    ti8(16);
    rst1();
    chk("t1_tec", 32'(bus.tec), 0);
    chk("t1_act", 32'(bus.erroractive), 1);

    ti8(16);
    chk("t2_tec", 32'(bus.tec), 128);
    chk("t2_pas", 32'(bus.errorpassive), 1);
    step(1,0,0,0,0,1,0);
    chk("t2_tec127", 32'(bus.tec), 127);
    chk("t2_act", 32'(bus.erroractive), 1);

    rst1();
    ti8(32);
    chk("t3_tec", 32'(bus.tec), 256);
    chk("t3_bo", 32'(bus.busoff), 1);
    step(1,1,0,0,0,1,0);
    step(1,0,1,1,1,1,0);
    chk("t3_hold", 32'(bus.tec), 256);
    chk("t3_rec", 32'(bus.rec), 0);

    sq(127);
    chk("t4_still", 32'(bus.busoff), 1);
    sq(1);
    chk("t4_tec", 32'(bus.tec), 0);
    chk("t4_act", 32'(bus.erroractive), 1);

    ri1(5);
    ti8(32);
    sq(64);
    rst1();
    ti8(32);
    sq(127);
    chk("t4_rst_still", 32'(bus.busoff), 1);
    sq(1);
    chk("t4_rst_act", 32'(bus.erroractive), 1);

    rst1();
    ri8(16); ri1(2);
    chk("t5_130", 32'(bus.rec), 130);
    step(1,0,0,1,0,0,0);
    chk("t5_reload", 32'(bus.rec), 120);
    ri8(16); ri1(2);
    ri8(1);
    chk("t5_sat", 32'(bus.rec), 255);
    ri1(1);
    rst1();
    step(1,0,0,1,0,1,0);
    ri1(10);
    step(1,1,1,1,0,0,0);
    chk("t5_18", 32'(bus.rec), 18);

    rst1();
    ti8(11);
    chk("t6_88", 32'(bus.warning), 0);
    ti8(1);
`ifdef FCE_WARNING_EN
    chk("t6_warn", 32'(bus.warning), 1);
`else
    chk("t6_warn", 32'(bus.warning), 0);
`endif

    rst1();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(999) != 0,
           $urandom_range(3) == 0,
           $urandom_range(5) == 0,
           $urandom_range(2) == 0,
           $urandom_range(2) == 0,
           $urandom_range(3) == 0,
           $urandom_range(1) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
